// File: rtl/module_shift_add_multiplier_pkg.sv
// pkg_multiplier: shared FSM state type and counter sizing for the shift-add multiplier.
package pkg_multiplier;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
    function automatic int cnt_width(input int wide);
        return $clog2(wide);
    endfunction
endpackage

// File: rtl/module_shift_add_multiplier_if.sv
// module_shift_add_multiplier_if: start/busy/done handshake, operands and product.
interface module_shift_add_multiplier_if #(parameter int MULWIDE = 8) ();
    logic                   start_i;
    logic [MULWIDE-1:0]     a_i;
    logic [MULWIDE-1:0]     b_i;
    logic                   busy_o;
    logic                   done_o;
    logic [2*MULWIDE-1:0]   product_o;
    modport master (output start_i, a_i, b_i, input busy_o, done_o, product_o);
    modport slave (input start_i, a_i, b_i, output busy_o, done_o, product_o);
endinterface

// File: rtl/module_shift_add_multiplier_rca.sv
// module_ripple_carry_adder: RCAWIDE-bit ripple carry adder with carry in/out.
module module_ripple_carry_adder import pkg_multiplier::*; #(
    parameter int RCAWIDE = 8
) (
    input  logic [RCAWIDE-1:0] a_i,
    input  logic [RCAWIDE-1:0] b_i,
    input  logic               carry_i,
    output logic [RCAWIDE-1:0] sum_o,
    output logic               carry_o
);
    logic [RCAWIDE:0] c;
    assign c[0] = carry_i;
    for (genvar i = 0; i < RCAWIDE; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign carry_o = c[RCAWIDE];
endmodule

// File: rtl/module_shift_add_multiplier.sv
// module_shift_add_multiplier: sequential unsigned add-and-shift multiplier, one bit per clock.
// Optional ZERO_BYPASS_EN: zero operands skip CALC and finish in one cycle.
module module_shift_add_multiplier import pkg_multiplier::*; #(
    parameter int MULWIDE = 8
) (
    input logic clk_i,
    input logic rst_i,
    module_shift_add_multiplier_if.slave bus
);
    localparam int CW = cnt_width(MULWIDE);
    localparam logic [CW-1:0] LAST = CW'(MULWIDE - 1);
    mul_state_t           state;
    logic [MULWIDE-1:0]   mcand, hi, lo, addend, sum, nhi, nlo;
    logic                 carry, busy, done, zero;
    logic [CW-1:0]        cnt;
    logic [2*MULWIDE-1:0] product;
    assign addend = lo[0] ? mcand : '0;
    module_ripple_carry_adder #(.RCAWIDE(MULWIDE)) u_rca (
        .a_i(hi), .b_i(addend), .carry_i(1'b0), .sum_o(sum), .carry_o(carry)
    );
    // Carry-out becomes the top bit after the shift, so full-scale products never overflow.
    assign nhi = {carry, sum[MULWIDE-1:1]};
    assign nlo = {sum[0], lo[MULWIDE-1:1]};
`ifdef ZERO_BYPASS_EN
    assign zero = (bus.a_i == '0) || (bus.b_i == '0);
`else
    assign zero = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
        end else if (state == CALC) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                product <= {nhi, nlo};
            end
        end else if (bus.start_i) begin
            mcand <= bus.a_i;
            hi    <= '0;
            lo    <= bus.b_i;
            cnt   <= '0;
            state <= zero ? DONE : CALC;
            busy  <= !zero;
            done  <= zero;
            if (zero) product <= '0;
        end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end
    end
    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.product_o = product;
endmodule
